// File: rtl/host_cmd_framer.sv
// host_cmd_framer
//   Expands one host command into the system command byte sequence and
//   serialises each byte as a UART frame on a single line:
//   start(0), 8 data bits LSB first, optional parity, stop(1), GAP_BITS idle bits.
//
//   Byte sequences:
//     CMD_TYPE 00 write        : AA, ADDR, DATA
//     CMD_TYPE 01 read         : BB, ADDR
//     CMD_TYPE 10 ALU operands : CC, DATA, OPB, FUN
//     CMD_TYPE 11 ALU no ops   : DD, FUN
//
// Parameters
//   BIT_CLKS  clock cycles per serial bit (>= 2)
//   GAP_BITS  idle bit periods after every stop bit (0..15)
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   CMD_VALID/READY  command handshake; READY is high exactly in IDLE
//   CMD_TYPE         command kind (see above)
//   CMD_ADDR/DATA/OPB/FUN  command byte fields
//   PAR_EN, PAR_TYP  parity enable / odd parity, sampled at accept
//   SER_OUT          registered serial line, idle high
//   BUSY             high while a command is on the line
//   CMD_DONE         one-cycle pulse in the first IDLE cycle after a command
module host_cmd_framer #(
  parameter int BIT_CLKS = 32,
  parameter int GAP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_TYPE,
  input  logic [7:0] CMD_ADDR,
  input  logic [7:0] CMD_DATA,
  input  logic [7:0] CMD_OPB,
  input  logic [7:0] CMD_FUN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       SER_OUT,
  output logic       BUSY,
  output logic       CMD_DONE
);

  localparam int CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);
  localparam logic [3:0] GAP_LAST = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [3:0]       gap_cnt, gap_cnt_nx;
  logic [1:0]       byte_idx, byte_idx_nx;
  logic             ser_r, ser_nx;
  logic             done_r, done_nx;

  logic [1:0]       type_r;
  logic [7:0]       addr_r, data_r, opb_r, fun_r;
  logic             par_en_r, par_typ_r;

  logic             accept;
  logic             bit_end;
  logic             last_byte;
  logic [7:0]       cur_byte;

  // Byte at position idx of the command's sequence.
  function automatic logic [7:0] sel_byte(input logic [1:0] typ, input logic [1:0] idx,
                                          input logic [7:0] addr, input logic [7:0] data,
                                          input logic [7:0] opb, input logic [7:0] fun);
    logic [7:0] b;
    b = 8'hFF;
    case (typ)
      2'b00: b = (idx == 2'd0) ? 8'hAA : (idx == 2'd1) ? addr : data;
      2'b01: b = (idx == 2'd0) ? 8'hBB : addr;
      2'b10: b = (idx == 2'd0) ? 8'hCC : (idx == 2'd1) ? data : (idx == 2'd2) ? opb : fun;
      default: b = (idx == 2'd0) ? 8'hDD : fun;
    endcase
    return b;
  endfunction

  // Index of the final byte for each command kind.
  function automatic logic [1:0] last_idx(input logic [1:0] typ);
    logic [1:0] n;
    case (typ)
      2'b00:   n = 2'd2;
      2'b10:   n = 2'd3;
      default: n = 2'd1;
    endcase
    return n;
  endfunction

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

  assign CMD_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);
  assign SER_OUT   = ser_r;
  assign CMD_DONE  = done_r;

  always_comb begin
    accept     = CMD_VALID && (state == S_IDLE) && !RST;
    bit_end    = (bit_cnt == BIT_LAST);
    cur_byte   = sel_byte(type_r, byte_idx, addr_r, data_r, opb_r, fun_r);
    last_byte  = (byte_idx == last_idx(type_r));

    state_nx    = state;
    bit_cnt_nx  = bit_end ? '0 : bit_cnt + CNT_W'(1);
    bit_idx_nx  = bit_idx;
    gap_cnt_nx  = gap_cnt;
    byte_idx_nx = byte_idx;
    done_nx     = 1'b0;
    ser_nx      = 1'b1;

    case (state)
      S_IDLE: begin
        bit_cnt_nx = '0;
        if (accept) begin
          state_nx    = S_START;
          byte_idx_nx = 2'd0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nx   = S_DATA;
          bit_idx_nx = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = par_en_r ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_nx = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (GAP_BITS > 0) begin
            state_nx   = S_GAP;
            gap_cnt_nx = 4'd0;
          end else if (last_byte) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx    = S_START;
            byte_idx_nx = byte_idx + 2'd1;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt_nx = gap_cnt + 4'd1;
          end else if (last_byte) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx    = S_START;
            byte_idx_nx = byte_idx + 2'd1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Line level is computed for the state being entered so the registered
    // output lines up with the state register.  Entering DATA or PARITY never
    // changes byte_idx, so cur_byte is already the right byte.
    case (state_nx)
      S_START:  ser_nx = 1'b0;
      S_DATA:   ser_nx = cur_byte[bit_idx_nx];
      S_PARITY: ser_nx = parity_bit(cur_byte, par_typ_r);
      default:  ser_nx = 1'b1;
    endcase
  end

  // Control state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      gap_cnt  <= 4'd0;
      byte_idx <= 2'd0;
      ser_r    <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      bit_idx  <= bit_idx_nx;
      gap_cnt  <= gap_cnt_nx;
      byte_idx <= byte_idx_nx;
      ser_r    <= ser_nx;
      done_r   <= done_nx;
    end
  end

  // Command capture: fields are frozen for the whole command.
  always_ff @(posedge CLK) begin
    if (accept) begin
      type_r    <= CMD_TYPE;
      addr_r    <= CMD_ADDR;
      data_r    <= CMD_DATA;
      opb_r     <= CMD_OPB;
      fun_r     <= CMD_FUN;
      par_en_r  <= PAR_EN;
      par_typ_r <= PAR_TYP;
    end
  end

endmodule

// File: doc/host_cmd_framer.md
# host_cmd_framer

Host-side command framer that sits directly upstream of the system top's serial receive input. It accepts one command per handshake and expands it into the system's command byte sequence: write, read, ALU-with-operands or ALU-without-operands. It then serialises each byte as a UART frame (start, 8 data bits LSB first, optional parity, stop, idle gap) on a single line. The line is driven from the same clock domain that clocks the receive side, and the block is used as the stimulus and driver stage in system-level benches and in the host FPGA shell.

## Interface
Parameters:
- BIT_CLKS, 32: clock cycles per serial bit (≥2).
- GAP_BITS, 1: idle (high) bit periods inserted after every stop bit (0–15).

Ports:
- CLK  in  1  block clock.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  framer can accept; high exactly when state = IDLE.
- CMD_TYPE  in  2  00 = reg write, 01 = reg read, 10 = ALU with operands, 11 = ALU without operands.
- CMD_ADDR  in  8  register address (write/read).
- CMD_DATA  in  8  write data (write) or operand A (ALU op).
- CMD_OPB  in  8  operand B (ALU op).
- CMD_FUN  in  8  ALU function (both ALU types).
- PAR_EN  in  1  parity enable, sampled at accept.
- PAR_TYP  in  1  0 = even, 1 = odd, sampled at accept.
- SER_OUT  out  1  serial line, idle high.
- BUSY  out  1  high from the cycle after accept until the last gap bit ends.
- CMD_DONE  out  1  one-cycle pulse when the command has fully left the line.

## Operation
- Accept: rising CLK edge with CMD_VALID & CMD_READY & !RST.
  - Registers CMD_TYPE, all byte fields, PAR_EN and PAR_TYP.
  - Input changes after accept have no effect on the frame in progress.
- Byte sequences (sent in this order):
  - write: 0xAA, ADDR, DATA (3 bytes).
  - read: 0xBB, ADDR (2 bytes).
  - ALU with operands: 0xCC, DATA, OPB, FUN (4 bytes).
  - ALU without operands: 0xDD, FUN (2 bytes).
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE → START on accept.
  - START → DATA.
  - DATA runs 8 bit periods, bit index 0..7, LSB first.
  - DATA → PARITY if PAR_EN, else DATA → STOP.
  - PARITY → STOP.
  - STOP → GAP if GAP_BITS > 0, else STOP → next byte or IDLE.
  - GAP → next byte's START, or → IDLE after the last byte.
- Every state other than IDLE lasts an integer number of bit periods of BIT_CLKS cycles, timed by a bit-clock counter 0..BIT_CLKS-1. State advances when the counter reaches BIT_CLKS-1.
- Line levels: START = 0; PARITY = XOR of the data byte, XOR PAR_TYP; STOP and GAP = 1; IDLE = 1.
- SER_OUT is registered; it never glitches within a bit period.
- CMD_VALID while busy is ignored and does not queue.

## Timing
- Reset, and the first cycle after RST deasserts:
  - SER_OUT = 1, BUSY = 0, CMD_DONE = 0, state = IDLE, all counters = 0.
  - CMD_READY = 1 from the first cycle after RST deasserts.
- RST asserted mid-frame: on the next edge SER_OUT = 1 and state = IDLE. No CMD_DONE is generated, and the partial frame is abandoned.
- Start bit timing: SER_OUT goes low in the cycle after the accept edge and holds for BIT_CLKS cycles.
- Command length: bytes × (10 + PAR_EN + GAP_BITS) × BIT_CLKS cycles, from the first start-bit cycle to the first cycle in IDLE.
- Completion: in that first IDLE cycle, CMD_DONE = 1 for one cycle, BUSY = 0 and CMD_READY = 1.
  - A new accept in this same cycle is legal.
  - With GAP_BITS = 0 this gives back-to-back frames: a stop bit followed directly by a start bit.
- CMD_READY is low for the whole command; it falls one cycle after the accept edge.

## Test plan
- Write, PAR_EN = 1, PAR_TYP = 0, BIT_CLKS = 4, GAP_BITS = 1, ADDR = 0x02, DATA = 0x81:
  - Bytes AA, 02, 81 with parity bits 0, 1, 0.
  - AA data bits 0,1,0,1,0,1,0,1.
  - CMD_DONE 144 cycles after the first start cycle.
- ALU without operands, PAR_EN = 0, FUN = 0x01, BIT_CLKS = 4:
  - Bytes DD, 01, no parity bit.
  - CMD_DONE after 88 cycles.
  - BUSY high for exactly 88 cycles.
- Read, PAR_TYP = 1 (odd), ADDR = 0x05:
  - BB parity bit = 1 (six ones) and 05 parity bit = 1.
  - Sampler at bit centres decodes BB, 05.
- ALU with operands A = 0x10, B = 0x20, FUN = 0x00:
  - Change all CMD_* and PAR_* inputs one cycle after accept.
  - Line still carries CC, 10, 20, 00 with the originally sampled parity.
  - CMD_VALID pulses while BUSY are ignored.
- Assert RST for 1 cycle during DATA of byte 2:
  - SER_OUT = 1 and CMD_READY = 1 next cycle, no CMD_DONE.
  - A new write accepted afterwards frames correctly.
- GAP_BITS = 0, CMD_VALID held high with two writes:
  - Second accept occurs in the CMD_DONE cycle.
  - Its start bit follows the prior stop bit with no idle period.
